alu_decode_stage: RTL and testbench
===================================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have port: Clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: InValid input 1, InReady output 1, InInstruction input 32, InPC input 32, InRegData1 input 32 (rs1 value), InRegData2 input 32 (rs2 value).
REQ-004 SHALL have port: Flush  input  1  discard all held and incoming instructions.
REQ-005 SHALL have ports: OutValid output 1, OutReady input 1, OutLHS output 32, OutRHS output 32, OutFunction output 4 (ALU function code).
REQ-006 SHALL have ports: OutCompareSel output 3 (index into the ALU Comparisons[5:0] bus), OutIsBranch output 1, OutBranchTarget output 32, OutRd output 5, OutWriteEnable output 1, OutIllegal output 1.

Function
REQ-007 SHALL transfer input when InValid && InReady, and output when OutValid && OutReady.
REQ-008 SHALL present a decoded instruction on Out* exactly 1 cycle after acceptance when the output stage is empty or draining.
REQ-009 SHALL sustain 1 instruction/cycle under continuous OutReady=1, using a 2-entry skid buffer (main register + skid register).
REQ-010 SHALL drive InReady = !skid_valid, registered; no combinational path from OutReady to InReady.
REQ-011 SHALL hold all Out* stable while OutValid && !OutReady; on stall, an accepted instruction goes to the skid entry, and InReady drops the following cycle.
REQ-012 SHALL deliver instructions in acceptance order; the skid entry moves to the main register on the cycle main drains.
REQ-013 SHALL decode OP (0110011): LHS=rs1, RHS=rs2, Function={funct7[5],funct3}, WriteEnable=(rd!=0).
REQ-014 SHALL decode OP-IMM (0010011): LHS=rs1, RHS=sign-extended imm[31:20], Function={funct3==101 ? funct7[5] : 0, funct3}; for funct3 001/101, RHS={27'd0,instr[24:20]}.
REQ-015 SHALL decode LUI (0110111): LHS=0, RHS={instr[31:12],12'd0}, Function=0000; AUIPC (0010111): LHS=InPC, same RHS, Function=0000.
REQ-016 SHALL decode BRANCH (1100011): LHS=rs1, RHS=rs2, Function=1000, IsBranch=1, WriteEnable=0, BranchTarget=InPC+sign-extended B-immediate (32-bit wrap).
REQ-017 SHALL map branch funct3 to CompareSel: BEQ000->5, BNE001->4, BLTU110->3, BLT100->2, BGEU111->1, BGE101->0; funct3 010/011 is illegal.
REQ-018 SHALL drive CompareSel=0, IsBranch=0, BranchTarget=0 for non-branch instructions.
REQ-019 SHALL treat other opcodes, OP with funct7 not in {0000000,0100000}, and OP with funct7=0100000 and funct3 not in {000,101} as illegal.
REQ-020 SHALL on Flush clear both entries next cycle (OutValid=0, InReady=1); Flush overrides a same-cycle input or output transfer, which is discarded.

Reset
REQ-021 SHALL, on Reset, clear main and skid valid bits: OutValid=0, InReady=1 on the following cycle.
REQ-022 SHALL reset all Out* data outputs to 0; Reset mid-stall discards held instructions; Reset overrides Flush.

Configuration
REQ-023 SHALL recognise macro DECODE_ILLEGAL_TRAP_EN.
REQ-024 With DECODE_ILLEGAL_TRAP_EN defined, an illegal instruction SHALL be emitted with OutIllegal=1, WriteEnable=0, IsBranch=0, Function=0000.
REQ-025 Without it, an illegal instruction SHALL be accepted and dropped (no output beat), and OutIllegal SHALL be tied 0.

Structure
REQ-026 SHALL take opcode constants, ALU function codes (0000 add ... 0111 and, 1000 sub, 1101 sra) and CompareSel indices from shared package alu_pkg, which the ALU also uses.
REQ-027 SHALL instantiate one sub-module decode_skid_buffer (parameterised payload width) for handshake/storage; decode logic stays in alu_decode_stage.

Verification
REQ-028 ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle OutFunction=0000, LHS=5, RHS=7, Rd=3, WriteEnable=1.
REQ-029 SUB 0x402081B3 -> Function=1000; SRAI x5,x6,3 (0x40335293) -> Function=1101, RHS=3, Rd=5.
REQ-030 BLT x1,x2,+16 (0x0020C863), PC=0x100 -> IsBranch=1, CompareSel=2, BranchTarget=0x110, WriteEnable=0.
REQ-031 LUI x1,0x12345 (0x123450B7) -> LHS=0, RHS=0x12345000; AUIPC same immediate, PC=0x1000 -> LHS=0x1000.
REQ-032 Back-to-back 3 instructions, OutReady=0 for 2 cycles -> InReady low after 2nd accept, no loss/reorder, all 3 emitted in order after OutReady=1.
REQ-033 Opcode 0x7F -> with macro: one beat OutIllegal=1; without: no beat. Flush with both entries full -> OutValid=0, InReady=1 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, ALU function codes, comparison-bus indices
// and the decoded payload carried from decode to execute.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // Bit positions within the ALU Comparisons[5:0] bus.
  localparam logic [2:0] CMP_GE  = 3'd0;
  localparam logic [2:0] CMP_GEU = 3'd1;
  localparam logic [2:0] CMP_LT  = 3'd2;
  localparam logic [2:0] CMP_LTU = 3'd3;
  localparam logic [2:0] CMP_NE  = 3'd4;
  localparam logic [2:0] CMP_EQ  = 3'd5;

  typedef struct packed {
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] target;
    logic [3:0]  fn;
    logic [2:0]  cmp_sel;
    logic        is_branch;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } decode_payload_t;

  localparam int PAYLOAD_W = $bits(decode_payload_t);

  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/decode_skid_buffer.sv
// Two-entry (main + skid) ready/valid buffer; in_ready depends only on
// registered state so there is no combinational out_ready -> in_ready path.
module decode_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             push;
  logic             pop;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign push      = in_valid && !skid_valid_q;
  assign pop       = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || pop) begin
      // Skid entry is always older than anything arriving now (in_ready was low).
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = push;
        if (push) begin
          main_data_d = in_data;
        end
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I ALU/branch decode stage feeding the ALU through a skid buffer.
// Define DECODE_ILLEGAL_TRAP_EN to emit illegal instructions flagged by OutIllegal
// instead of silently dropping them.
module alu_decode_stage
  import alu_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] InInstruction,
  input  logic [31:0] InPC,
  input  logic [31:0] InRegData1,
  input  logic [31:0] InRegData2,
  input  logic        Flush,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutLHS,
  output logic [31:0] OutRHS,
  output logic [3:0]  OutFunction,
  output logic [2:0]  OutCompareSel,
  output logic        OutIsBranch,
  output logic [31:0] OutBranchTarget,
  output logic [4:0]  OutRd,
  output logic        OutWriteEnable,
  output logic        OutIllegal
);

  decode_payload_t dec;
  decode_payload_t out_pl;
  logic            illegal;
  logic            keep;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [31:0]     u_imm;

  assign opcode = InInstruction[6:0];
  assign rd     = InInstruction[11:7];
  assign funct3 = InInstruction[14:12];
  assign funct7 = InInstruction[31:25];
  assign u_imm  = {InInstruction[31:12], 12'd0};

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.lhs = InRegData1;
        dec.rhs = InRegData2;
        dec.fn  = {funct7[5], funct3};
        dec.rd  = rd;
        dec.we  = (rd != 5'd0);
        if (funct7 == 7'b0100000) begin
          illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
        end else if (funct7 != 7'b0000000) begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.lhs = InRegData1;
        // Shifts take a 5-bit unsigned shamt; bit 30 selects SRAI.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.rhs = {27'd0, InInstruction[24:20]};
        end else begin
          dec.rhs = {{20{InInstruction[31]}}, InInstruction[31:20]};
        end
        dec.fn = {(funct3 == 3'b101) ? InInstruction[30] : 1'b0, funct3};
        dec.rd = rd;
        dec.we = (rd != 5'd0);
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.lhs = (opcode == OPC_AUIPC) ? InPC : 32'd0;
        dec.rhs = u_imm;
        dec.fn  = ALU_ADD;
        dec.rd  = rd;
        dec.we  = (rd != 5'd0);
      end
      OPC_BRANCH: begin
        dec.lhs       = InRegData1;
        dec.rhs       = InRegData2;
        dec.fn        = ALU_SUB;
        dec.is_branch = 1'b1;
        dec.target    = InPC + b_imm(InInstruction);
        case (funct3)
          3'b000:  dec.cmp_sel = CMP_EQ;
          3'b001:  dec.cmp_sel = CMP_NE;
          3'b100:  dec.cmp_sel = CMP_LT;
          3'b101:  dec.cmp_sel = CMP_GE;
          3'b110:  dec.cmp_sel = CMP_LTU;
          3'b111:  dec.cmp_sel = CMP_GEU;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (illegal) begin
      dec = '0;
      dec.illegal = 1'b1;
    end
`endif
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign keep = 1'b1;
`else
  // Illegal instructions are still handshaken in, just never stored.
  assign keep = !illegal;
`endif

  decode_skid_buffer #(
    .WIDTH(PAYLOAD_W)
  ) u_skid (
    .clk      (Clock),
    .srst     (Reset),
    .flush    (Flush),
    .in_valid (InValid && keep),
    .in_ready (InReady),
    .in_data  (dec),
    .out_valid(OutValid),
    .out_ready(OutReady),
    .out_data (out_pl)
  );

  assign OutLHS          = out_pl.lhs;
  assign OutRHS          = out_pl.rhs;
  assign OutFunction     = out_pl.fn;
  assign OutCompareSel   = out_pl.cmp_sel;
  assign OutIsBranch     = out_pl.is_branch;
  assign OutBranchTarget = out_pl.target;
  assign OutRd           = out_pl.rd;
  assign OutWriteEnable  = out_pl.we;
  assign OutIllegal      = out_pl.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage (honours DECODE_ILLEGAL_TRAP_EN).
module tb_alu_decode_stage;

  logic        Clock = 1'b0;
  logic        Reset, InValid, InReady, Flush, OutValid, OutReady;
  logic [31:0] InInstruction, InPC, InRegData1, InRegData2;
  logic [31:0] OutLHS, OutRHS, OutBranchTarget;
  logic [3:0]  OutFunction;
  logic [2:0]  OutCompareSel;
  logic [4:0]  OutRd;
  logic        OutIsBranch, OutWriteEnable, OutIllegal;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        v;
    logic [3:0]  fn;
    logic [2:0]  cs;
    logic        br;
    logic        we;
    logic        ill;
    logic [4:0]  rd;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] tgt;
  } beat_t;

  alu_decode_stage dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InInstruction(InInstruction), .InPC(InPC), .InRegData1(InRegData1),
    .InRegData2(InRegData2), .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
    .OutLHS(OutLHS), .OutRHS(OutRHS), .OutFunction(OutFunction),
    .OutCompareSel(OutCompareSel), .OutIsBranch(OutIsBranch),
    .OutBranchTarget(OutBranchTarget), .OutRd(OutRd),
    .OutWriteEnable(OutWriteEnable), .OutIllegal(OutIllegal)
  );

  always #5 Clock = ~Clock;

  function automatic beat_t observe();
    return '{OutValid, OutFunction, OutCompareSel, OutIsBranch, OutWriteEnable,
             OutIllegal, OutRd, OutLHS, OutRHS, OutBranchTarget};
  endfunction

  function automatic beat_t mk(input logic [3:0] fn, input logic [2:0] cs, input logic br,
                               input logic we, input logic [4:0] rd, input logic [31:0] lhs,
                               input logic [31:0] rhs, input logic [31:0] tgt);
    return '{1'b1, fn, cs, br, we, 1'b0, rd, lhs, rhs, tgt};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    InValid = 1'b1; InInstruction = ins; InPC = pc; InRegData1 = r1; InRegData2 = r2;
  endtask

  task automatic test_reset();
    beat_t b;
    Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    InInstruction = '0; InPC = '0; InRegData1 = '0; InRegData2 = '0;
    step(); step();
    b = observe();
    n_cmp++;
    if (b !== beat_t'('0)) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", b);
    end else $display("ok reset_outputs");
    n_cmp++;
    if (InReady !== 1'b1) begin
      n_err++; $display("FAIL reset_inready: got %b want 1", InReady);
    end else $display("ok reset_inready");
    Reset = 1'b0;
    step();
  endtask

  task automatic test_add();
    beat_t b, e;
    OutReady = 1'b1;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    step();
    InValid = 1'b0;
    b = observe(); e = mk(4'b0000, 3'd0, 1'b0, 1'b1, 5'd3, 32'd5, 32'd7, 32'd0);
    n_cmp++;
    if (b !== e) begin n_err++; $display("FAIL add: got %h want %h", b, e); end
    else $display("ok add: %h", b);
    step();
    n_cmp++;
    if (OutValid !== 1'b0) begin n_err++; $display("FAIL add_drain: got %b want 0", OutValid); end
    else $display("ok add_drain");
    // rd = x0 must not write
    drive(32'h00208033, 32'h0, 32'd1, 32'd2);
    step();
    InValid = 1'b0;
    b = observe(); e = mk(4'b0000, 3'd0, 1'b0, 1'b0, 5'd0, 32'd1, 32'd2, 32'd0);
    n_cmp++;
    if (b !== e) begin n_err++; $display("FAIL add_x0: got %h want %h", b, e); end
    else $display("ok add_x0: %h", b);
    step();
  endtask

  task automatic test_throughput();
    beat_t b, e;
    OutReady = 1'b1;
    drive(32'h402081B3, 32'h0, 32'd9, 32'd4);           // SUB x3,x1,x2
    step();
    b = observe(); e = mk(4'b1000, 3'd0, 1'b0, 1'b1, 5'd3, 32'd9, 32'd4, 32'd0);
    drive(32'h40335293, 32'h0, 32'h80, 32'h0);          // SRAI x5,x6,3
    n_cmp++;
    if (b !== e) begin n_err++; $display("FAIL sub: got %h want %h", b, e); end
    else $display("ok sub: %h", b);
    step();
    b = observe(); e = mk(4'b1101, 3'd0, 1'b0, 1'b1, 5'd5, 32'h80, 32'd3, 32'd0);
    drive(32'hFFF10093, 32'h0, 32'd42, 32'h0);          // ADDI x1,x2,-1
    n_cmp++;
    if (b !== e) begin n_err++; $display("FAIL srai: got %h want %h", b, e); end
    else $display("ok srai: %h", b);
    step();
    InValid = 1'b0;
    b = observe(); e = mk(4'b0000, 3'd0, 1'b0, 1'b1, 5'd1, 32'd42, 32'hFFFF_FFFF, 32'd0);
    n_cmp++;
    if (b !== e) begin n_err++; $display("FAIL addi_neg: got %h want %h", b, e); end
    else $display("ok addi_neg: %h", b);
    step();
    n_cmp++;
    if (OutValid !== 1'b0) begin n_err++; $display("FAIL tput_drain: got %b want 0", OutValid); end
    else $display("ok tput_drain");
  endtask

  task automatic test_branch();
    beat_t b, e;
    OutReady = 1'b1;
    drive(32'h0020C863, 32'h100, 32'd1, 32'd2);         // BLT +16
    step();
    b = observe(); e = mk(4'b1000, 3'd2, 1'b1, 1'b0, 5'd0, 32'd1, 32'd2, 32'h110);
    drive(32'h00209863, 32'hFFFF_FFF8, 32'd3, 32'd4);   // BNE +16, target wraps
    n_cmp++;
    if (b !== e) begin n_err++; $display("FAIL blt: got %h want %h", b, e); end
    else $display("ok blt: %h", b);
    step();
    b = observe(); e = mk(4'b1000, 3'd4, 1'b1, 1'b0, 5'd0, 32'd3, 32'd4, 32'h8);
    drive(32'h0020F863, 32'h200, 32'd5, 32'd6);         // BGEU +16
    n_cmp++;
    if (b !== e) begin n_err++; $display("FAIL bne_wrap: got %h want %h", b, e); end
    else $display("ok bne_wrap: %h", b);
    step();
    b = observe(); e = mk(4'b1000, 3'd1, 1'b1, 1'b0, 5'd0, 32'd5, 32'd6, 32'h210);
    drive(32'h00208863, 32'h300, 32'd7, 32'd7);         // BEQ +16
    n_cmp++;
    if (b !== e) begin n_err++; $display("FAIL bgeu: got %h want %h", b, e); end
    else $display("ok bgeu: %h", b);
    step();
    InValid = 1'b0;
    b = observe(); e = mk(4'b1000, 3'd5, 1'b1, 1'b0, 5'd0, 32'd7, 32'd7, 32'h310);
    n_cmp++;
    if (b !== e) begin n_err++; $display("FAIL beq: got %h want %h", b, e); end
    else $display("ok beq: %h", b);
    step();
  endtask

  task automatic test_lui_auipc();
    beat_t b, e;
    OutReady = 1'b1;
    drive(32'h123450B7, 32'h500, 32'hDEAD, 32'hBEEF);   // LUI x1,0x12345
    step();
    b = observe(); e = mk(4'b0000, 3'd0, 1'b0, 1'b1, 5'd1, 32'd0, 32'h12345000, 32'd0);
    drive(32'h12345097, 32'h1000, 32'hDEAD, 32'hBEEF);  // AUIPC x1,0x12345
    n_cmp++;
    if (b !== e) begin n_err++; $display("FAIL lui: got %h want %h", b, e); end
    else $display("ok lui: %h", b);
    step();
    InValid = 1'b0;
    b = observe(); e = mk(4'b0000, 3'd0, 1'b0, 1'b1, 5'd1, 32'h1000, 32'h12345000, 32'd0);
    n_cmp++;
    if (b !== e) begin n_err++; $display("FAIL auipc: got %h want %h", b, e); end
    else $display("ok auipc: %h", b);
    step();
  endtask

  task automatic test_back_to_back();
    beat_t b, e1, e2, e3;
    e1 = mk(4'b0000, 3'd0, 1'b0, 1'b1, 5'd1, 32'd11, 32'd2, 32'd0);
    e2 = mk(4'b0000, 3'd0, 1'b0, 1'b1, 5'd2, 32'd22, 32'd2, 32'd0);
    e3 = mk(4'b0000, 3'd0, 1'b0, 1'b1, 5'd3, 32'd33, 32'd2, 32'd0);
    OutReady = 1'b0;
    drive(32'h002080B3, 32'h0, 32'd11, 32'd2);          // ADD x1
    step();
    drive(32'h00208133, 32'h0, 32'd22, 32'd2);          // ADD x2
    step();
    b = observe();
    n_cmp++;
    if (InReady !== 1'b0 || b !== e1) begin
      n_err++; $display("FAIL b2b_stall1: ready %b beat %h want ready 0 beat %h", InReady, b, e1);
    end else $display("ok b2b_stall1: %h", b);
    drive(32'h002081B3, 32'h0, 32'd33, 32'd2);          // ADD x3, held off
    step();
    b = observe();
    n_cmp++;
    if (InReady !== 1'b0 || b !== e1) begin
      n_err++; $display("FAIL b2b_stall2: ready %b beat %h want ready 0 beat %h", InReady, b, e1);
    end else $display("ok b2b_stall2: %h", b);
    OutReady = 1'b1;
    step();
    b = observe();
    n_cmp++;
    if (InReady !== 1'b1 || b !== e2) begin
      n_err++; $display("FAIL b2b_second: ready %b beat %h want ready 1 beat %h", InReady, b, e2);
    end else $display("ok b2b_second: %h", b);
    step();
    InValid = 1'b0;
    b = observe();
    n_cmp++;
    if (b !== e3) begin n_err++; $display("FAIL b2b_third: got %h want %h", b, e3); end
    else $display("ok b2b_third: %h", b);
    step();
    n_cmp++;
    if (OutValid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", OutValid); end
    else $display("ok b2b_drain");
  endtask

  task automatic test_illegal();
    OutReady = 1'b1;
    drive(32'h0000007F, 32'h0, 32'd1, 32'd2);
    step();
    InValid = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    n_cmp++;
    if ({OutValid, OutIllegal, OutWriteEnable, OutIsBranch, OutFunction} !== 8'b1100_0000) begin
      n_err++; $display("FAIL illegal_trap: got v%b ill%b we%b br%b fn%h want v1 ill1 we0 br0 fn0",
                        OutValid, OutIllegal, OutWriteEnable, OutIsBranch, OutFunction);
    end else $display("ok illegal_trap");
    step();
    n_cmp++;
    if (OutValid !== 1'b0) begin n_err++; $display("FAIL illegal_one_beat: got %b want 0", OutValid); end
    else $display("ok illegal_one_beat");
`else
    n_cmp++;
    if (OutValid !== 1'b0 || OutIllegal !== 1'b0 || InReady !== 1'b1) begin
      n_err++; $display("FAIL illegal_drop: v%b ill%b ready%b want v0 ill0 ready1",
                        OutValid, OutIllegal, InReady);
    end else $display("ok illegal_drop");
    // branch funct3 010 and OP with funct7=0100000/funct3=001 are also dropped
    drive(32'h0020A863, 32'h0, 32'd1, 32'd2);
    step();
    drive(32'h40209033, 32'h0, 32'd1, 32'd2);
    n_cmp++;
    if (OutValid !== 1'b0) begin n_err++; $display("FAIL illegal_branch_drop: got %b want 0", OutValid); end
    else $display("ok illegal_branch_drop");
    step();
    InValid = 1'b0;
    n_cmp++;
    if (OutValid !== 1'b0) begin n_err++; $display("FAIL illegal_op_drop: got %b want 0", OutValid); end
    else $display("ok illegal_op_drop");
`endif
    step();
  endtask

  task automatic test_flush();
    OutReady = 1'b0;
    drive(32'h002080B3, 32'h0, 32'd1, 32'd2);
    step();
    drive(32'h00208133, 32'h0, 32'd3, 32'd4);
    step();
    n_cmp++;
    if (OutValid !== 1'b1 || InReady !== 1'b0) begin
      n_err++; $display("FAIL flush_fill: v%b ready%b want v1 ready0", OutValid, InReady);
    end else $display("ok flush_fill");
    Flush = 1'b1; OutReady = 1'b1;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd6);
    step();
    Flush = 1'b0; InValid = 1'b0;
    n_cmp++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      n_err++; $display("FAIL flush_clear: v%b ready%b want v0 ready1", OutValid, InReady);
    end else $display("ok flush_clear");
    step();
    n_cmp++;
    if (OutValid !== 1'b0) begin n_err++; $display("FAIL flush_discard: got %b want 0", OutValid); end
    else $display("ok flush_discard");
  endtask

  task automatic test_reset_mid_stall();
    OutReady = 1'b0;
    drive(32'h002080B3, 32'h0, 32'd1, 32'd2);
    step();
    drive(32'h00208133, 32'h0, 32'd3, 32'd4);
    step();
    InValid = 1'b0;
    Reset = 1'b1; Flush = 1'b1;
    step();
    Reset = 1'b0; Flush = 1'b0; OutReady = 1'b1;
    n_cmp++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || OutLHS !== 32'd0 || OutRd !== 5'd0) begin
      n_err++; $display("FAIL reset_stall: v%b ready%b lhs%h rd%0d want v0 ready1 lhs0 rd0",
                        OutValid, InReady, OutLHS, OutRd);
    end else $display("ok reset_stall");
    step();
    n_cmp++;
    if (OutValid !== 1'b0) begin n_err++; $display("FAIL reset_stall_after: got %b want 0", OutValid); end
    else $display("ok reset_stall_after");
  endtask

  initial begin
    test_reset();
    test_add();
    test_throughput();
    test_branch();
    test_lui_auipc();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
